mem_ctrl: RTL and testbench
===========================

# mem_ctrl

CPU-side memory access controller that sits directly upstream of `mmio` and the main RAM. It decodes each CPU load/store by address and routes it to the synchronous RAM (below `16'hFF00`) or the MMIO block (`16'hFF00`–`16'hFFFF`). It performs byte-lane steering and stalls the CPU through a request/ready handshake. It also absorbs MMIO wait states and bounds MMIO reads with a timeout.

## Interface
Parameters:
- `MMIO_TIMEOUT`, default 4: maximum cycles to wait for `mmio_serviced` before aborting a read.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cpu_req` in 1: access request; held stable with `cpu_we`/`cpu_byte`/`cpu_addr`/`cpu_wdata` until `cpu_ready`.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_byte` in 1: 1 = byte access, 0 = word access.
- `cpu_addr` in 16: byte address.
- `cpu_wdata` in 16: store data; byte stores use `[7:0]`.
- `cpu_rdata` out 16: load data, registered, valid while `cpu_ready`=1.
- `cpu_ready` out 1: one-cycle completion pulse.
- `cpu_err` out 1: one-cycle pulse with `cpu_ready` on timeout or misaligned word access.
- `ram_en` out 1: RAM strobe.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out 15: RAM word address.
- `ram_be` out 2: byte enables; bit0 = low byte.
- `ram_wdata` out 16: RAM write data.
- `ram_rdata` in 16: RAM read data, valid one cycle after strobe.
- `mmio_en` out 1: MMIO strobe.
- `mmio_we` out 1: MMIO write enable.
- `mmio_byte_select` out 1: `cpu_addr[0]`.
- `mmio_byte_enable` out 1: `cpu_byte`.
- `mmio_addr` out 16: `{1'b0, cpu_addr[15:1]}`.
- `mmio_wdata` out 16: `cpu_wdata`.
- `mmio_rdata` in 16: MMIO read data.
- `mmio_serviced` in 1: MMIO read data valid.
- `mmio_wait` in 1: MMIO cannot accept a write this cycle.

## Operation
- **Decode:** `is_mmio = cpu_addr >= 16'hFF00`.
- **Word accesses:** ignore `cpu_addr[0]`. An odd word address completes normally, aligned down, and pulses `cpu_err`.
- **States:** IDLE, RAM_RD, MMIO_RD, MMIO_WR, DONE.
- **IDLE:** strobes are driven combinationally from the CPU inputs when `cpu_req`=1.
  - RAM store → DONE.
  - RAM load → RAM_RD.
  - MMIO load → MMIO_RD.
  - MMIO store → MMIO_WR if `mmio_wait`=1, else DONE.
- **RAM_RD:** capture `ram_rdata`. Byte load returns the selected lane zero-extended (`addr[0]`=0 → `[7:0]`, 1 → `[15:8]`). Word load returns the full word. → DONE.
- **Byte store:** data is replicated to both lanes; `ram_be` = `addr[0] ? 2'b10 : 2'b01`. Word store: `ram_be` = `2'b11`.
- **MMIO_RD:** the strobe is not reasserted; the timeout counter increments.
  - On `mmio_serviced`: capture `mmio_rdata`, byte-masked as for RAM → DONE.
  - On `counter == MMIO_TIMEOUT`: `cpu_rdata` = 0, `cpu_err` → DONE.
- **MMIO_WR:** hold `mmio_en`/`mmio_we`/data. On the first cycle with `mmio_wait`=0 → DONE. No timeout on writes.
- **DONE:** `cpu_ready`=1 for exactly one cycle; `cpu_req` is ignored → IDLE.
- **Reset (any state, mid-transaction included):** immediate return to IDLE; the aborted access never produces `cpu_ready`.

## Timing
- **Reset values:** `cpu_rdata`=0, `cpu_ready`=0, `cpu_err`=0, counter=0, state=IDLE. All strobes are 0 because they depend only on IDLE and `cpu_req`.
- **Latency** (request accepted in cycle 0):
  - RAM store: ready in cycle 1.
  - RAM load: ready in cycle 2.
  - MMIO load: ready in cycle 2 with nominal `mmio_serviced` in cycle 1.
  - MMIO store: ready in cycle 1 + number of `mmio_wait` cycles.
  - MMIO timeout: ready in cycle `MMIO_TIMEOUT`+1.
- **Back-to-back:** a new request is accepted at the earliest in the cycle after `cpu_ready`, so maximum throughput is one RAM store per 2 cycles.
- **Strobe width:** exactly one cycle per access, except MMIO_WR, which holds the strobe while waiting.
- `mmio_serviced` arriving in IDLE or DONE is ignored.

## Structure
- `cpu_constants.vh` gains:
  - `MMIO_BASE` (16'hFF00)
  - state encodings `MC_IDLE`..`MC_DONE`
  - default `MMIO_TIMEOUT`
- One sub-module, `mem_lane_steer` (combinational): byte/word write replication, `ram_be` generation, and read-lane extraction. It is shared by the RAM and MMIO paths.

## Test plan
- **RAM byte store:** `addr`=0x0103, `wdata`=0x00A5, `cpu_byte`=1 → `ram_addr`=0x0081, `ram_be`=10, `ram_wdata`=0xA5A5; ready in cycle 1.
- **RAM word load:** `addr`=0x0200, `ram_rdata`=0x1234 → `cpu_rdata`=0x1234, ready in cycle 2. Repeat with byte load at 0x0201 → 0x0012.
- **MMIO LED write:** `addr`=0xFF00, byte, `wdata`=0x5A → `mmio_addr`=0x7F80, `mmio_byte_select`=0, `mmio_we`=1. Readback gives `cpu_rdata`=0x005A in cycle 2.
- **MMIO UART write with `mmio_wait` high for 3 cycles** → strobe held 4 cycles, ready in cycle 4, no `cpu_err`.
- **MMIO read to 0xFF10 with `mmio_serviced` never asserted** → `cpu_rdata`=0, `cpu_err`=1 with ready in cycle 5.
- **`rst_n` low during RAM_RD** → no `cpu_ready`, all outputs 0. A new load after release completes normally. Also check that a misaligned word load at 0x0201 flags `cpu_err`.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared constants and types for the CPU-side memory access controller:
// MMIO window base, controller state encoding, default MMIO read timeout and
// an address-decode helper.
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    typedef logic [15:0] word_t;

    // Addresses at or above this value belong to the MMIO block, below it to RAM.
    localparam word_t MMIO_BASE = 16'hFF00;

    // Cycles an MMIO read may wait for mmio_serviced before it is aborted.
    localparam int MMIO_TIMEOUT_DEFAULT = 4;

    typedef enum logic [2:0] {
        MC_IDLE    = 3'd0,
        MC_RAM_RD  = 3'd1,
        MC_MMIO_RD = 3'd2,
        MC_MMIO_WR = 3'd3,
        MC_DONE    = 3'd4
    } mc_state_t;

    function automatic logic is_mmio_addr(input word_t addr);
        return addr >= MMIO_BASE;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if
// CPU request/ready bus between the CPU core (master) and mem_ctrl (slave).
//   cpu_req/cpu_we/cpu_byte/cpu_addr/cpu_wdata : request, held until cpu_ready
//   cpu_rdata                                  : registered load data
//   cpu_ready / cpu_err                        : one-cycle completion / error
// -----------------------------------------------------------------------------
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic  cpu_req;
    logic  cpu_we;
    logic  cpu_byte;
    word_t cpu_addr;
    word_t cpu_wdata;
    word_t cpu_rdata;
    logic  cpu_ready;
    logic  cpu_err;

    modport master (
        output cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_err
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_err
    );

endinterface

// File: rtl/mem_lane_steer.sv
// -----------------------------------------------------------------------------
// mem_lane_steer
// Combinational byte-lane steering shared by the RAM and MMIO paths.
//   byte_acc  : 1 = byte access, 0 = word access
//   lane_hi   : byte address bit 0 (selects the upper lane on byte accesses)
//   wdata_in  : CPU store data          -> wdata_out : lane-replicated store data
//                                        -> be        : byte enables, bit0 = low
//   rdata_in  : raw 16-bit read data    -> rdata_out : selected lane, zero-ext.
// -----------------------------------------------------------------------------
module mem_lane_steer
    import mem_ctrl_pkg::*;
(
    input  logic       byte_acc,
    input  logic       lane_hi,
    input  word_t      wdata_in,
    input  word_t      rdata_in,
    output word_t      wdata_out,
    output logic [1:0] be,
    output word_t      rdata_out
);

    // Byte stores put the byte on both lanes so the enables alone pick the target.
    assign wdata_out = byte_acc ? {2{wdata_in[7:0]}} : wdata_in;
    assign be        = byte_acc ? (lane_hi ? 2'b10 : 2'b01) : 2'b11;
    assign rdata_out = byte_acc ? {8'h00, (lane_hi ? rdata_in[15:8] : rdata_in[7:0])}
                                : rdata_in;

endmodule

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// CPU-side memory access controller. Decodes each load/store by address,
// routes it to the synchronous RAM or the MMIO block, steers byte lanes and
// stalls the CPU until the access completes. MMIO writes absorb mmio_wait;
// MMIO reads are bounded by MMIO_TIMEOUT.
//   clk, rst_n          : clock, asynchronous active-low reset
//   cpu                 : CPU request/ready bus (mem_ctrl_if.slave)
//   ram_*               : RAM strobe, write enable, word address, enables, data
//   mmio_*              : MMIO strobe, write enable, lane select, address, data,
//                         read data, serviced flag and write wait
// -----------------------------------------------------------------------------
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MMIO_TIMEOUT = MMIO_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_ctrl_if.slave   cpu,
    output logic        ram_en,
    output logic        ram_we,
    output logic [14:0] ram_addr,
    output logic [1:0]  ram_be,
    output word_t       ram_wdata,
    input  word_t       ram_rdata,
    output logic        mmio_en,
    output logic        mmio_we,
    output logic        mmio_byte_select,
    output logic        mmio_byte_enable,
    output word_t       mmio_addr,
    output word_t       mmio_wdata,
    input  word_t       mmio_rdata,
    input  logic        mmio_serviced,
    input  logic        mmio_wait
);

    localparam int CW = $clog2(MMIO_TIMEOUT + 1);

    mc_state_t     state_q, state_d;
    word_t         rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    word_t rd_src;
    word_t lane_rdata;
    logic  is_mmio;
    logic  misaligned;

    assign is_mmio    = is_mmio_addr(cpu.cpu_addr);
    assign misaligned = !cpu.cpu_byte && cpu.cpu_addr[0];

    // Addresses and data follow the held CPU request; only the strobes qualify them.
    assign ram_addr         = cpu.cpu_addr[15:1];
    assign mmio_addr        = {1'b0, cpu.cpu_addr[15:1]};
    assign mmio_byte_select = cpu.cpu_addr[0];
    assign mmio_byte_enable = cpu.cpu_byte;
    assign mmio_wdata       = cpu.cpu_wdata;
    assign cpu.cpu_rdata    = rdata_q;

    // RAM_RD is the only state that captures RAM data; MMIO_RD uses the MMIO bus.
    assign rd_src = (state_q == MC_RAM_RD) ? ram_rdata : mmio_rdata;

    mem_lane_steer u_steer (
        .byte_acc  (cpu.cpu_byte),
        .lane_hi   (cpu.cpu_addr[0]),
        .wdata_in  (cpu.cpu_wdata),
        .rdata_in  (rd_src),
        .wdata_out (ram_wdata),
        .be        (ram_be),
        .rdata_out (lane_rdata)
    );

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MC_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case statement can infer a latch.
        state_d       = state_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        cnt_d         = cnt_q;
        ram_en        = 1'b0;
        ram_we        = 1'b0;
        mmio_en       = 1'b0;
        mmio_we       = 1'b0;
        cpu.cpu_ready = 1'b0;
        cpu.cpu_err   = 1'b0;

        unique case (state_q)
            MC_IDLE: begin
                if (cpu.cpu_req) begin
                    err_d = misaligned;
                    cnt_d = '0;
                    if (is_mmio) begin
                        mmio_en = 1'b1;
                        mmio_we = cpu.cpu_we;
                        if (!cpu.cpu_we) begin
                            // The accept cycle counts as the first wait cycle.
                            state_d = MC_MMIO_RD;
                            cnt_d   = CW'(1);
                        end else if (mmio_wait) begin
                            state_d = MC_MMIO_WR;
                        end else begin
                            state_d = MC_DONE;
                        end
                    end else begin
                        ram_en  = 1'b1;
                        ram_we  = cpu.cpu_we;
                        state_d = cpu.cpu_we ? MC_DONE : MC_RAM_RD;
                    end
                end
            end
            MC_RAM_RD: begin
                rdata_d = lane_rdata;
                state_d = MC_DONE;
            end
            MC_MMIO_RD: begin
                // A response in the timeout cycle still wins over the abort.
                if (mmio_serviced) begin
                    rdata_d = lane_rdata;
                    state_d = MC_DONE;
                end else if (cnt_q == CW'(MMIO_TIMEOUT)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = MC_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            MC_MMIO_WR: begin
                mmio_en = 1'b1;
                mmio_we = 1'b1;
                if (!mmio_wait) state_d = MC_DONE;
            end
            MC_DONE: begin
                cpu.cpu_ready = 1'b1;
                cpu.cpu_err   = err_q;
                cnt_d         = '0;
                state_d       = MC_IDLE;
            end
            default: state_d = MC_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
// Self-checking bench for mem_ctrl. Expected responses come from a byte-level
// reference memory and are queued per request; a monitor pops and compares
// whenever cpu_ready pulses. RAM and MMIO devices are modelled behaviourally.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ram_en, ram_we;
    logic [14:0] ram_addr;
    logic [1:0]  ram_be;
    logic [15:0] ram_wdata, ram_rdata;
    logic        mmio_en, mmio_we, mmio_byte_select, mmio_byte_enable;
    logic [15:0] mmio_addr, mmio_wdata, mmio_rdata;
    logic        mmio_serviced, mmio_wait;

    mem_ctrl_if cpu ();

    mem_ctrl #(.MMIO_TIMEOUT(T)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cpu              (cpu),
        .ram_en           (ram_en),
        .ram_we           (ram_we),
        .ram_addr         (ram_addr),
        .ram_be           (ram_be),
        .ram_wdata        (ram_wdata),
        .ram_rdata        (ram_rdata),
        .mmio_en          (mmio_en),
        .mmio_we          (mmio_we),
        .mmio_byte_select (mmio_byte_select),
        .mmio_byte_enable (mmio_byte_enable),
        .mmio_addr        (mmio_addr),
        .mmio_wdata       (mmio_wdata),
        .mmio_rdata       (mmio_rdata),
        .mmio_serviced    (mmio_serviced),
        .mmio_wait        (mmio_wait)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- device models ----------------
    bit [15:0] ram_mem  [0:32767];
    bit [15:0] mmio_regs[0:127];

    initial ram_rdata = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                if (ram_be[0]) ram_mem[ram_addr][7:0]  <= ram_wdata[7:0];
                if (ram_be[1]) ram_mem[ram_addr][15:8] <= ram_wdata[15:8];
            end else begin
                ram_rdata <= ram_mem[ram_addr];
            end
        end
    end

    always @(posedge clk) begin
        if (mmio_en && mmio_we && !mmio_wait) begin
            if (!mmio_byte_enable)     mmio_regs[mmio_addr[6:0]]       <= mmio_wdata;
            else if (mmio_byte_select) mmio_regs[mmio_addr[6:0]][15:8] <= mmio_wdata[7:0];
            else                       mmio_regs[mmio_addr[6:0]][7:0]  <= mmio_wdata[7:0];
        end
    end

    // ---------------- reference model + scoreboard ----------------
    bit [7:0] ref_b [0:65535];

    typedef struct {
        logic [15:0] rdata;
        logic        chk_rdata;
        logic        err;
        int          accept;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cpu.cpu_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_ready", cpu.cpu_ready, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    check("ready_latency", cyc - mon_e.accept, mon_e.lat);
                    if (mon_e.chk_rdata) check("cpu_rdata", cpu.cpu_rdata, mon_e.rdata);
                    check("cpu_err", cpu.cpu_err, mon_e.err);
                end
            end else if (cpu.cpu_err) begin
                check("err_without_ready", cpu.cpu_err, 1'b0);
            end
        end
    end

    // cycle-0 snapshot of the strobes, taken by do_access
    logic        s_ram_en, s_ram_we, s_mmio_en, s_mmio_we, s_bsel, s_ben;
    logic [14:0] s_ram_addr;
    logic [1:0]  s_ram_be;
    logic [15:0] s_ram_wdata, s_mmio_addr, s_mmio_wdata;

    task automatic drive_env(input logic we, input logic mm, input logic [15:0] addr,
                             input int nwait, input int svc, input int k);
        logic hit;
        hit = !we && mm && (k == svc);
        mmio_wait     = (we && mm) ? (k < nwait) : 1'($urandom_range(0, 1));
        mmio_serviced = (!we && mm) ? (hit || (k == 0 && $urandom_range(0, 1) == 1))
                                    : 1'($urandom_range(0, 1));
        mmio_rdata    = hit ? mmio_regs[addr[7:1]] : 16'($urandom);
    endtask

    // Issue one access (called just after a rising edge) and wait for its completion.
    // svc: cycle of mmio_serviced for MMIO loads, -1 = never.
    task automatic do_access(input logic we, input logic bt, input logic [15:0] addr,
                             input logic [15:0] wd, input int nwait, input int svc);
        exp_t        e;
        logic        mm;
        logic [15:0] a0;
        int          k, strobes, exp_strobes;
        mm          = (addr >= 16'hFF00);
        a0          = {addr[15:1], 1'b0};
        e.accept    = cyc;
        e.err       = !bt && addr[0];
        e.chk_rdata = !we;
        e.rdata     = bt ? {8'h00, ref_b[addr]} : {ref_b[a0 + 16'd1], ref_b[a0]};
        if (we)                     e.lat = mm ? 1 + nwait : 1;
        else if (!mm)               e.lat = 2;
        else if (svc >= 1 && svc <= T) e.lat = svc + 1;
        else begin
            e.lat   = T + 1;
            e.rdata = '0;
            e.err   = 1'b1;
        end
        sb.push_back(e);
        exp_strobes = (we && mm) ? 1 + nwait : 1;
        if (we) begin
            if (bt) ref_b[addr] = wd[7:0];
            else begin
                ref_b[a0]         = wd[7:0];
                ref_b[a0 + 16'd1] = wd[15:8];
            end
        end

        cpu.cpu_req   = 1'b1;
        cpu.cpu_we    = we;
        cpu.cpu_byte  = bt;
        cpu.cpu_addr  = addr;
        cpu.cpu_wdata = wd;
        k = 0;
        strobes = 0;
        drive_env(we, mm, addr, nwait, svc, k);
        forever begin
            @(negedge clk);
            if (k == 0) begin
                s_ram_en = ram_en;     s_ram_we = ram_we;     s_ram_addr = ram_addr;
                s_ram_be = ram_be;     s_ram_wdata = ram_wdata;
                s_mmio_en = mmio_en;   s_mmio_we = mmio_we;   s_mmio_addr = mmio_addr;
                s_bsel = mmio_byte_select; s_ben = mmio_byte_enable; s_mmio_wdata = mmio_wdata;
            end
            strobes += int'(ram_en | mmio_en);
            if (cpu.cpu_ready) break;
            if (k >= 20) begin
                check("ready_seen", cpu.cpu_ready, 1'b1);
                break;
            end
            @(posedge clk);
            #1;
            k++;
            drive_env(we, mm, addr, nwait, svc, k);
        end
        @(posedge clk);
        #1;
        cpu.cpu_req   = 1'b0;
        mmio_wait     = 1'b0;
        mmio_serviced = 1'b0;
        check("strobe_cycles", strobes, exp_strobes);
        check("ram_sel", s_ram_en, !mm);
        check("mmio_sel", s_mmio_en, mm);
        check("we_out", mm ? s_mmio_we : s_ram_we, we);
        if (!mm) check("ram_be", s_ram_be, bt ? (addr[0] ? 2'b10 : 2'b01) : 2'b11);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, cpu.cpu_ready, 1'b0);
        check({tag, "_err"}, cpu.cpu_err, 1'b0);
        check({tag, "_rdata"}, cpu.cpu_rdata, 16'h0000);
        check({tag, "_strobes"}, {ram_en, ram_we, mmio_en, mmio_we}, 4'b0000);
        check({tag, "_addrs"}, {1'b0, ram_addr, mmio_addr}, 32'h0);
    endtask

    task automatic zero_inputs();
        cpu.cpu_req = 1'b0; cpu.cpu_we = 1'b0; cpu.cpu_byte = 1'b0;
        cpu.cpu_addr = '0; cpu.cpu_wdata = '0;
        mmio_rdata = '0; mmio_serviced = 1'b0; mmio_wait = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        rst_n = 1'b0;
        zero_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // RAM byte store: lane steering and one-cycle completion
        do_access(1'b1, 1'b1, 16'h0103, 16'h00A5, 0, 0);
        check("bstore_ram_addr", s_ram_addr, 15'h0081);
        check("bstore_ram_be", s_ram_be, 2'b10);
        check("bstore_ram_wdata", s_ram_wdata, 16'hA5A5);

        // RAM word store then word / byte / misaligned-word loads
        do_access(1'b1, 1'b0, 16'h0200, 16'h1234, 0, 0);
        do_access(1'b0, 1'b0, 16'h0200, 16'h0000, 0, 0);
        do_access(1'b0, 1'b1, 16'h0201, 16'h0000, 0, 0);
        do_access(1'b0, 1'b0, 16'h0201, 16'h0000, 0, 0);

        // MMIO LED byte write and readback
        do_access(1'b1, 1'b1, 16'hFF00, 16'h005A, 0, 0);
        check("led_mmio_addr", s_mmio_addr, 16'h7F80);
        check("led_byte_select", s_bsel, 1'b0);
        check("led_byte_enable", s_ben, 1'b1);
        check("led_mmio_wdata", s_mmio_wdata, 16'h005A);
        do_access(1'b0, 1'b1, 16'hFF00, 16'h0000, 0, 1);

        // MMIO write held off by three wait cycles, then read back at max wait
        do_access(1'b1, 1'b0, 16'hFF04, 16'hBEEF, 3, 0);
        do_access(1'b0, 1'b0, 16'hFF04, 16'h0000, 0, T);

        // MMIO read that is never serviced
        do_access(1'b0, 1'b0, 16'hFF10, 16'h0000, 0, -1);

        // Reset during RAM_RD: aborted load never completes
        cpu.cpu_req = 1'b1; cpu.cpu_we = 1'b0; cpu.cpu_byte = 1'b0; cpu.cpu_addr = 16'h0200;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        zero_inputs();
        #1;
        check_quiet("midreset");
        repeat (3) begin
            @(negedge clk);
            check("midreset_no_ready", cpu.cpu_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_access(1'b0, 1'b0, 16'h0200, 16'h0000, 0, 0);

        // RAM/MMIO boundary
        do_access(1'b1, 1'b0, 16'hFEFE, 16'hC3D2, 0, 0);
        do_access(1'b0, 1'b1, 16'hFEFF, 16'h0000, 0, 0);

        // Randomized traffic, mostly back-to-back
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 16'($urandom_range(0, 63));
                1:       a = 16'hFEF8 + 16'($urandom_range(0, 7));
                2:       a = 16'hFF00 + 16'($urandom_range(0, 31));
                default: a = 16'hFFF8 + 16'($urandom_range(0, 7));
            endcase
            do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom),
                      $urandom_range(0, 3),
                      ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, T)));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
